// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM state
// encoding, status bit positions and the command validity check.
package alu_cmd_pkg;

    // ALU opcodes carried in the low nibble of the first command byte
    localparam logic [3:0] OP_EQ  = 4'd0;
    localparam logic [3:0] OP_GT  = 4'd1;
    localparam logic [3:0] OP_LT  = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_DIV = 4'd6;
    localparam logic [3:0] OP_MAX = 4'd6;

    // Bit positions inside the status byte
    localparam int ST_INVALID = 0;
    localparam int ST_DIV0    = 1;

    // Sequencer state encoding (7 states, 3 bits)
    localparam logic [2:0] ENC_GET_OP  = 3'd0;
    localparam logic [2:0] ENC_GET_A   = 3'd1;
    localparam logic [2:0] ENC_GET_B   = 3'd2;
    localparam logic [2:0] ENC_EXEC    = 3'd3;
    localparam logic [2:0] ENC_SEND_S  = 3'd4;
    localparam logic [2:0] ENC_SEND_A1 = 3'd5;
    localparam logic [2:0] ENC_SEND_A2 = 3'd6;

    typedef enum logic [2:0] {
        S_GET_OP  = ENC_GET_OP,
        S_GET_A   = ENC_GET_A,
        S_GET_B   = ENC_GET_B,
        S_EXEC    = ENC_EXEC,
        S_SEND_S  = ENC_SEND_S,
        S_SEND_A1 = ENC_SEND_A1,
        S_SEND_A2 = ENC_SEND_A2
    } seq_state_t;

    // Error flags for a captured command: unknown opcode or non-zero upper
    // nibble marks it invalid; a divide by zero is flagged separately.
    function automatic logic [1:0] cmd_flags(input logic [3:0] opcode,
                                             input logic [3:0] upper,
                                             input logic [7:0] operand_2);
        logic [1:0] f;
        f             = 2'b00;
        f[ST_INVALID] = (opcode > OP_MAX) || (upper != 4'h0);
        f[ST_DIV0]    = (opcode == OP_DIV) && (operand_2 == 8'h00);
        return f;
    endfunction

endpackage

// File: rtl/alu_rsp_serializer.sv
// Response serializer: takes {status, ans1, ans2} in one parallel load and
// presents them as three bytes on a valid/ready stream, last on the third.
// out_data/out_last hold while out_valid && !out_ready; out_data reads 0
// whenever nothing is being offered.
module alu_rsp_serializer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] status,
    input  logic [W-1:0] ans1,
    input  logic [W-1:0] ans2,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last
);

    logic [3*W-1:0] bytes_q;
    logic [1:0]     idx_q;
    logic           valid_q;

    // Load the response, then step through its bytes on each handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bytes_q <= '0;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
        end else if (load) begin
            bytes_q <= {status, ans1, ans2};
            idx_q   <= 2'd0;
            valid_q <= 1'b1;
        end else if (valid_q && out_ready) begin
            if (idx_q == 2'd2) begin
                idx_q   <= 2'd0;
                valid_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    // Select the byte currently on offer
    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (valid_q) begin
            case (idx_q)
                2'd0:    out_data = bytes_q[3*W-1:2*W];
                2'd1:    out_data = bytes_q[2*W-1:W];
                2'd2:    out_data = bytes_q[W-1:0];
                default: out_data = '0;
            endcase
            out_last = (idx_q == 2'd2);
        end
    end

    assign out_valid = valid_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side initiator for the combinational 8-bit ALU. Collects a 3-byte
// command (operator, operand_1, operand_2), holds the ALU inputs in
// registers for one execute cycle, then returns (status, answer1, answer2).
// Both streams use valid/ready: a byte moves on a rising edge where valid
// and ready are both high; a producer never drops valid or changes data
// before that edge. Only one command is in flight at a time.
module alu_cmd_sequencer
    import alu_cmd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [DATA_W-1:0] alu_operand_1,
    output logic [DATA_W-1:0] alu_operand_2,
    output logic [OP_W-1:0]   alu_operator,
    input  logic [DATA_W-1:0] alu_answer1,
    input  logic [DATA_W-1:0] alu_answer2,
    output logic              err_pulse
);

    seq_state_t               state_q, state_d;
    logic [DATA_W-OP_W-1:0]   upper_q;
    logic [OP_W-1:0]          op_q;
    logic [DATA_W-1:0]        opnd1_q, opnd2_q;
    logic                     err_q;
    logic                     ready_c;
    logic                     load;
    logic                     accept;
    logic                     rsp_fire;
    logic [1:0]               flags;
    logic [DATA_W-1:0]        status_c, ans1_c, ans2_c;

    // ready is forced low while reset is held so nothing is taken mid-reset
    assign in_ready = ready_c & rst_n;
    assign accept   = in_valid && in_ready;
    assign rsp_fire = out_valid && out_ready;

    // Next-state and control decode for the command/response sequence
    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            S_GET_OP: begin
                ready_c = 1'b1;
                if (in_valid) state_d = S_GET_A;
            end
            S_GET_A: begin
                ready_c = 1'b1;
                if (in_valid) state_d = S_GET_B;
            end
            S_GET_B: begin
                ready_c = 1'b1;
                if (in_valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                load    = 1'b1;
                state_d = S_SEND_S;
            end
            S_SEND_S: begin
                if (rsp_fire) state_d = S_SEND_A1;
            end
            S_SEND_A1: begin
                if (rsp_fire) state_d = S_SEND_A2;
            end
            S_SEND_A2: begin
                if (rsp_fire) state_d = S_GET_OP;
            end
            default: state_d = S_GET_OP;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_GET_OP;
        else        state_q <= state_d;
    end

    // Capture command bytes into the registers that feed the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            upper_q <= '0;
            opnd1_q <= '0;
            opnd2_q <= '0;
        end else if (accept) begin
            if (state_q == S_GET_OP) begin
                op_q    <= in_data[OP_W-1:0];
                upper_q <= in_data[DATA_W-1:OP_W];
            end else if (state_q == S_GET_A) begin
                opnd1_q <= in_data;
            end else if (state_q == S_GET_B) begin
                opnd2_q <= in_data;
            end
        end
    end

    // Build status and gate ALU answers during the execute cycle
    always_comb begin
        flags    = cmd_flags(op_q, upper_q, opnd2_q);
        status_c = {op_q, 2'b00, flags};
        ans1_c   = alu_answer1;
        ans2_c   = alu_answer2;
        if (flags != 2'b00) begin
            ans1_c = '0;
            ans2_c = '0;
        end
    end

    // Error pulse lines up with the first cycle the status byte is offered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= load && (flags != 2'b00);
    end

    assign err_pulse     = err_q;
    assign alu_operator  = op_q;
    assign alu_operand_1 = opnd1_q;
    assign alu_operand_2 = opnd2_q;

    alu_rsp_serializer #(
        .W(DATA_W)
    ) u_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .status    (status_c),
        .ans1      (ans1_c),
        .ans2      (ans2_c),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule
